// File: rtl/jtkiwi_pkg.sv
// Shared constants for the Kiwi ROM arbiter: FSM encoding, requester indices
// and the round-robin pick helper.
package jtkiwi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic TILE = 1'b0;
  localparam logic OBJ  = 1'b1;

  // With both requesting, prio names the winner; otherwise the lone requester wins.
  function automatic logic rr_pick(input logic prio, input logic t_req, input logic o_req);
    logic g;
    if (t_req && o_req) g = prio;
    else                g = o_req ? OBJ : TILE;
    return g;
  endfunction

endpackage

// File: rtl/jtkiwi_romarb_cache.sv
// One-entry read cache (address, data, valid) for a single ROM requester.
module jtkiwi_romarb_cache #(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_i) begin
      addr_q  <= wr_addr_i;
      data_q  <= wr_data_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (addr_q == rd_addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/jtkiwi_romarb.sv
// Two-requester (tile/object) round-robin arbiter onto one SDRAM ROM port.
// Optional per-requester one-entry cache when JTKIWI_ROMARB_CACHE_EN is defined.
module jtkiwi_romarb
  import jtkiwi_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          t_cs,
  input  logic [AW-1:0] t_addr,
  output logic [DW-1:0] t_data,
  output logic          t_ok,
  input  logic          o_cs,
  input  logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          prio_q, prio_d;
  logic          settle_q, settle_d;
  logic          abort_q, abort_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] t_data_q, t_data_d, o_data_q, o_data_d;
  logic          t_ok_q, t_ok_d, o_ok_q, o_ok_d;

  logic          any_cs, pick, g_cs, drop, rom_done, pick_hit;
  logic [AW-1:0] pick_addr, g_addr;
  logic [DW-1:0] pick_cdata;

  assign any_cs    = t_cs | o_cs;
  assign pick      = rr_pick(prio_q, t_cs, o_cs);
  assign pick_addr = (pick == OBJ) ? o_addr : t_addr;
  assign g_cs      = (grant_q == OBJ) ? o_cs : t_cs;
  assign g_addr    = (grant_q == OBJ) ? o_addr : t_addr;
  // A granted requester that lets go or moves its address forfeits the result.
  assign drop      = !g_cs || (g_addr != rom_addr_q);
  assign rom_done  = (state_q == BUSY) && !settle_q && rom_ok;

`ifdef JTKIWI_ROMARB_CACHE_EN
  logic          t_hit, o_hit;
  logic [DW-1:0] t_cdata, o_cdata;

  jtkiwi_romarb_cache #(.AW(AW), .DW(DW)) u_t_cache (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_i      (rom_done && (grant_q == TILE)),
    .wr_addr_i (rom_addr_q),
    .wr_data_i (rom_data),
    .rd_addr_i (t_addr),
    .hit_o     (t_hit),
    .data_o    (t_cdata)
  );

  jtkiwi_romarb_cache #(.AW(AW), .DW(DW)) u_o_cache (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_i      (rom_done && (grant_q == OBJ)),
    .wr_addr_i (rom_addr_q),
    .wr_data_i (rom_data),
    .rd_addr_i (o_addr),
    .hit_o     (o_hit),
    .data_o    (o_cdata)
  );

  assign pick_hit   = (pick == OBJ) ? o_hit : t_hit;
  assign pick_cdata = (pick == OBJ) ? o_cdata : t_cdata;
`else
  assign pick_hit   = 1'b0;
  assign pick_cdata = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_cs) state_d = pick_hit ? DONE : BUSY;
      BUSY:    if (rom_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    prio_d     = prio_q;
    settle_d   = settle_q;
    abort_d    = abort_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    t_data_d   = t_data_q;
    o_data_d   = o_data_q;
    t_ok_d     = 1'b0;
    o_ok_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_cs) begin
          grant_d = pick;
          prio_d  = !pick;
          abort_d = 1'b0;
          if (pick_hit) begin
            if (pick == OBJ) begin
              o_data_d = pick_cdata;
              o_ok_d   = 1'b1;
            end else begin
              t_data_d = pick_cdata;
              t_ok_d   = 1'b1;
            end
          end else begin
            rom_cs_d   = 1'b1;
            rom_addr_d = pick_addr;
            settle_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        // First BUSY cycle only settles: rom_ok may still reflect the old address.
        settle_d = 1'b0;
        abort_d  = abort_q | drop;
        if (rom_done) begin
          rom_cs_d = 1'b0;
          if (!(abort_q || drop)) begin
            if (grant_q == OBJ) begin
              o_data_d = rom_data;
              o_ok_d   = 1'b1;
            end else begin
              t_data_d = rom_data;
              t_ok_d   = 1'b1;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= TILE;
      prio_q     <= TILE;
      settle_q   <= 1'b0;
      abort_q    <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      t_data_q   <= '0;
      o_data_q   <= '0;
      t_ok_q     <= 1'b0;
      o_ok_q     <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      settle_q   <= settle_d;
      abort_q    <= abort_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      t_data_q   <= t_data_d;
      o_data_q   <= o_data_d;
      t_ok_q     <= t_ok_d;
      o_ok_q     <= o_ok_d;
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign t_data   = t_data_q;
  assign o_data   = o_data_q;
  assign t_ok     = t_ok_q;
  assign o_ok     = o_ok_q;

endmodule

// File: tb/tb_jtkiwi_romarb.sv
// Scoreboard bench for jtkiwi_romarb: directed corner cases plus random traffic
// from two requesters against a simple SDRAM responder.
module tb_jtkiwi_romarb;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          t_cs = 1'b0, o_cs = 1'b0;
  logic [AW-1:0] t_addr = '0, o_addr = '0;
  logic [DW-1:0] t_data, o_data;
  logic          t_ok, o_ok;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  always #5 clk = ~clk;

  jtkiwi_romarb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .t_cs     (t_cs),
    .t_addr   (t_addr),
    .t_data   (t_data),
    .t_ok     (t_ok),
    .o_cs     (o_cs),
    .o_addr   (o_addr),
    .o_data   (o_data),
    .o_ok     (o_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {a[11:0], a[19:0]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // SDRAM responder: data lags the address by one cycle, ok after a per-access delay
  logic [AW-1:0] addr_d1 = '0;
  int  rcnt = 0, rlat = 1, fix_lat = -1;
  bit  hold_ok = 1'b0;
  always @(posedge clk) begin
    addr_d1 <= rom_addr;
    if (!rom_cs) begin
      rcnt <= 0;
      rlat <= (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
    end else rcnt <= rcnt + 1;
  end
  assign rom_data = memfn(addr_d1);
  assign rom_ok   = hold_ok || (rom_cs && (rcnt >= rlat));

  // Scoreboard state
  logic [DW-1:0] exp_t[$], exp_o[$];
  bit            served[$];
  logic [DW-1:0] last_t = '0, last_o = '0;
  int            rc_cnt = 0;

  initial begin : monitor
    bit prev_t, prev_o;
    logic [DW-1:0] e;
    prev_t = 0; prev_o = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rom_cs) rc_cnt++;
        if (t_ok) begin
          chk("t_ok_single_cycle", prev_t, 0);
          chk("t_ok_with_cs", t_cs, 1);
          chk("ok_exclusive", o_ok, 0);
          if (exp_t.size() == 0) chk("t_ok_unexpected", 1, 0);
          else begin
            e = exp_t.pop_front();
            chk("t_data", t_data, e);
            last_t = e;
          end
          served.push_back(1'b0);
        end else chk("t_data_hold", t_data, last_t);
        if (o_ok) begin
          chk("o_ok_single_cycle", prev_o, 0);
          chk("o_ok_with_cs", o_cs, 1);
          if (exp_o.size() == 0) chk("o_ok_unexpected", 1, 0);
          else begin
            e = exp_o.pop_front();
            chk("o_data", o_data, e);
            last_o = e;
          end
          served.push_back(1'b1);
        end else chk("o_data_hold", o_data, last_o);
        prev_t = t_ok;
        prev_o = o_ok;
      end else begin
        prev_t = 0; prev_o = 0;
      end
    end
  end

  task automatic req(input bit who, input logic [AW-1:0] a, output int lat);
    int start;
    bit got;
    @(posedge clk); #1;
    if (who) begin o_addr = a; o_cs = 1'b1; exp_o.push_back(memfn(a)); end
    else     begin t_addr = a; t_cs = 1'b1; exp_t.push_back(memfn(a)); end
    start = cyc;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (who ? o_ok : t_ok) got = 1;
    end
    lat = cyc - start;
    if (!got) begin
      chk(who ? "o_req_timeout" : "t_req_timeout", 0, 1);
      lat = -1;
    end
    @(posedge clk); #1;
    if (who) o_cs = 1'b0; else t_cs = 1'b0;
  endtask

  task automatic wait_rom_cs();
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rom_cs) got = 1;
    end
    chk("rom_cs_seen", got, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin : main
    int l1, l2, l3, rc0, n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_t_ok", t_ok, 0);
    chk("rst_o_ok", o_ok, 0);
    chk("rst_t_data", t_data, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst_n = 1'b1;

    // Single tile access
    fix_lat = 2;
    served.delete();
    fork
      req(1'b0, 20'h01234, l1);
      begin wait_rom_cs(); chk("rom_addr_tile", rom_addr, 20'h01234); end
    join
    chk("single_served_n", served.size(), 1);

    // rom_ok stuck high: settle cycle must still be honoured
    hold_ok = 1'b1;
    req(1'b0, 20'h02345, l1);
    chk("lat_hold_tile", l1, 3);
    req(1'b1, 20'h02346, l1);
    chk("lat_hold_obj", l1, 3);
    hold_ok = 1'b0;

    // Round robin with both requesting together
    fix_lat = -1;
    served.delete();
    fork
      begin req(1'b0, 20'h00A00, l1); req(1'b0, 20'h00A01, l2); end
      req(1'b1, 20'h00B00, l3);
    join
    chk("rr_served_n", served.size(), 3);
    if (served.size() >= 3) begin
      chk("rr_first_tile", served[0], 0);
      chk("rr_second_obj", served[1], 1);
      chk("rr_third_tile", served[2], 0);
    end

    // Object drops cs during BUSY
    fix_lat = 3;
    served.delete();
    @(posedge clk); #1;
    o_addr = 20'h03456; o_cs = 1'b1;
    wait_rom_cs();
    o_cs = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rom_cs) break;
      n++;
    end
    chk("abort_rom_cs_cycles", n, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_ok", served.size(), 0);
    chk("abort_o_data", o_data, last_o);

    // Reset in the middle of an access
    @(posedge clk); #1;
    t_addr = 20'h04567; t_cs = 1'b1;
    wait_rom_cs();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rom_cs", rom_cs, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_t_ok", t_ok, 0);
    chk("midrst_t_data", t_data, 0);
    chk("midrst_o_data", o_data, 0);
    t_cs = 1'b0;
    exp_t.delete(); exp_o.delete();
    last_t = '0; last_o = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    served.delete();
    fix_lat = -1;
    fork
      req(1'b0, 20'h05000, l1);
      req(1'b1, 20'h05001, l2);
    join
    chk("postrst_served_n", served.size(), 2);
    if (served.size() >= 2) begin
      chk("postrst_tile_first", served[0], 0);
      chk("postrst_obj_second", served[1], 1);
    end

    // Repeated address: cache hit when enabled, SDRAM otherwise
    hold_ok = 1'b1;
    req(1'b0, 20'h00010, l1);
    chk("rep_first_lat", l1, 3);
    rc0 = rc_cnt;
    req(1'b0, 20'h00010, l2);
`ifdef JTKIWI_ROMARB_CACHE_EN
    chk("cache_hit_lat", l2, 1);
    chk("cache_hit_no_rom_cs", rc_cnt - rc0, 0);
    req(1'b0, 20'h00020, l3);
    chk("cache_miss_lat", l3, 3);
`else
    chk("nocache_rep_lat", l2, 3);
    chk("nocache_rep_rom_cs", rc_cnt - rc0, 2);
`endif
    hold_ok = 1'b0;

    // Random traffic from both requesters
    fork
      begin
        int lt;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          req(1'b0, 20'h00100 + AW'($urandom_range(0, 5)), lt);
        end
      end
      begin
        int lo;
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          req(1'b1, 20'h00100 + AW'($urandom_range(0, 5)), lo);
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("drain_t", exp_t.size(), 0);
    chk("drain_o", exp_o.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
